alu_arbiter: RTL and testbench

Shares the single ALU between two requesters, such as the control-unit sequencer and a micro-op helper, using a valid/ready request handshake and a one-cycle response pulse. The block latches the winning request's operation and operands and drives them to the ALU for the configured latency. It then captures the ALU result and returns it to the requester that issued it. It sits between the requesters and the ALU instance, and is the only block that drives the ALU's `ALU_Operation`, `AC` and `Bus` inputs.

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Purpose : shares one ALU between two requesters; round-robin on ties, or fixed priority to req0 when ALU_ARB_FIXED_PRIO_EN is defined.
// Latency : rspN_valid pulses in the cycle after edge E0+ALU_LATENCY+1 (E0 = acceptance edge); issue interval is ALU_LATENCY+2.
// Backpressure: reqN_ready only in IDLE for the arbitration winner; responses have no backpressure and must be sampled on rspN_valid.
module alu_arbiter #(
    parameter int         reg_width   = 12,
    parameter int         ALU_LATENCY = 1,
    parameter logic [2:0] IDLE_OP     = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2:0]           req0_op,
    input  logic [reg_width-1:0] req0_ac,
    input  logic [reg_width-1:0] req0_bus,
    output logic                 rsp0_valid,
    output logic [reg_width-1:0] rsp0_result,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2:0]           req1_op,
    input  logic [reg_width-1:0] req1_ac,
    input  logic [reg_width-1:0] req1_bus,
    output logic                 rsp1_valid,
    output logic [reg_width-1:0] rsp1_result,
    output logic [2:0]           alu_op,
    output logic [reg_width-1:0] alu_ac,
    output logic [reg_width-1:0] alu_bus,
    input  logic [reg_width-1:0] alu_result,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // EXEC lasts ALU_LATENCY cycles: the counter is loaded with one less and leaves EXEC on zero.
    localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           cnt_q;
    logic                 grant_q;
    logic                 pick1;
    logic                 arb_open;
    logic                 accept;
    logic [2:0]           win_op;
    logic [reg_width-1:0] win_ac;
    logic [reg_width-1:0] win_bus;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                 last_grant_q;
`endif

    // Arbitration: choose requester 1 only when it alone is valid or it is its turn on a tie.
    always_comb begin
        pick1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick1 = req1_valid && !req0_valid;
`else
        if (req0_valid && req1_valid) begin
            pick1 = !last_grant_q;
        end else begin
            pick1 = req1_valid;
        end
`endif
    end

    // Ready is combinational, only in IDLE and never while reset is held low.
    assign arb_open   = (state_q == IDLE) && reset;
    assign req0_ready = arb_open && req0_valid && !pick1;
    assign req1_ready = arb_open && req1_valid && pick1;
    assign accept     = req0_ready || req1_ready;
    assign win_op     = pick1 ? req1_op  : req0_op;
    assign win_ac     = pick1 ? req1_ac  : req0_ac;
    assign win_bus    = pick1 ? req1_bus : req0_bus;
    assign busy       = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> EXEC on accept, EXEC -> CAPTURE when the count expires, CAPTURE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the winner onto the ALU inputs, count latency, return the result to the issuer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= 4'd0;
            grant_q      <= 1'b0;
            alu_op       <= IDLE_OP;
            alu_ac       <= '0;
            alu_bus      <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_result  <= '0;
            rsp1_result  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_op       <= win_op;
                        alu_ac       <= win_ac;
                        alu_bus      <= win_bus;
                        grant_q      <= pick1;
                        cnt_q        <= CNT_LOAD;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_q <= pick1;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                CAPTURE: begin
                    // Acceptance is impossible here (ready is low), so the ALU inputs always idle after capture.
                    if (grant_q) begin
                        rsp1_result <= alu_result;
                        rsp1_valid  <= 1'b1;
                    end else begin
                        rsp0_result <= alu_result;
                        rsp0_valid  <= 1'b1;
                    end
                    alu_op  <= IDLE_OP;
                    alu_ac  <= '0;
                    alu_bus <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam logic [2:0] IDLE_OP = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b111;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b011;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid;
    logic [2:0]  req0_op;
    logic [11:0] req0_ac, req0_bus, rsp0_result;
    logic        req1_valid, req1_ready, rsp1_valid;
    logic [2:0]  req1_op;
    logic [11:0] req1_ac, req1_bus, rsp1_result;
    logic [2:0]  alu_op;
    logic [11:0] alu_ac, alu_bus, alu_result;
    logic        busy;

    logic        b_req0_valid, b_req0_ready, b_rsp0_valid;
    logic [2:0]  b_req0_op;
    logic [11:0] b_req0_ac, b_req0_bus, b_rsp0_result;
    logic        b_req1_valid, b_req1_ready, b_rsp1_valid;
    logic [2:0]  b_req1_op;
    logic [11:0] b_req1_ac, b_req1_bus, b_rsp1_result;
    logic [2:0]  b_alu_op;
    logic [11:0] b_alu_ac, b_alu_bus, b_alu_result, b_p1, b_p2;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.reg_width(12), .ALU_LATENCY(1), .IDLE_OP(IDLE_OP)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_ac(req0_ac), .req0_bus(req0_bus), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_ac(req1_ac), .req1_bus(req1_bus), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .alu_op(alu_op), .alu_ac(alu_ac), .alu_bus(alu_bus), .alu_result(alu_result), .busy(busy)
    );

    alu_arbiter #(.reg_width(12), .ALU_LATENCY(3), .IDLE_OP(IDLE_OP)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
        .req0_ac(b_req0_ac), .req0_bus(b_req0_bus), .rsp0_valid(b_rsp0_valid), .rsp0_result(b_rsp0_result),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
        .req1_ac(b_req1_ac), .req1_bus(b_req1_bus), .rsp1_valid(b_rsp1_valid), .rsp1_result(b_rsp1_result),
        .alu_op(b_alu_op), .alu_ac(b_alu_ac), .alu_bus(b_alu_bus), .alu_result(b_alu_result), .busy(b_busy)
    );

    function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [11:0] ac, input logic [11:0] bus);
        case (op)
            OP_XOR:  return ac ^ bus;
            OP_AND:  return ac & bus;
            OP_ADD:  return ac + bus;
            default: return ac;
        endcase
    endfunction

    // ALU models: one register stage for dut, three for dut3.
    always_ff @(posedge clk) begin
        alu_result   <= alu_f(alu_op, alu_ac, alu_bus);
        b_p1         <= alu_f(b_alu_op, b_alu_ac, b_alu_bus);
        b_p2         <= b_p1;
        b_alu_result <= b_p2;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v0;
        logic [2:0]  op0;
        logic [11:0] ac0;
        logic [11:0] bus0;
        logic        v1;
        logic [2:0]  op1;
        logic [11:0] ac1;
        logic [11:0] bus1;
        logic        gnt;
        logic [11:0] res;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [2:0] op0, input logic [11:0] ac0, input logic [11:0] bus0,
                                input logic v1, input logic [2:0] op1, input logic [11:0] ac1, input logic [11:0] bus1,
                                input logic gnt, input logic [11:0] res);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.ac0 = ac0; v.bus0 = bus0;
        v.v1 = v1; v.op1 = op1; v.ac1 = ac1; v.bus1 = bus1;
        v.gnt = gnt; v.res = res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one request right now (just after a falling edge) and checks the whole
    // accept / EXEC / CAPTURE / response sequence of the latency-1 instance.
    task automatic run_vec(input vec_t v, input string tag);
        logic [2:0]  eop;
        logic [11:0] eac, ebus;
        req0_valid = v.v0; req0_op = v.op0; req0_ac = v.ac0; req0_bus = v.bus0;
        req1_valid = v.v1; req1_op = v.op1; req1_ac = v.ac1; req1_bus = v.bus1;
        #1;
        chk({tag, " ready0"}, 32'(req0_ready), 32'(v.v0 && !v.gnt));
        chk({tag, " ready1"}, 32'(req1_ready), 32'(v.v1 && v.gnt));
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        eop  = v.gnt ? v.op1  : v.op0;
        eac  = v.gnt ? v.ac1  : v.ac0;
        ebus = v.gnt ? v.bus1 : v.bus0;
        @(posedge clk);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            chk({tag, " busy"},    32'(busy),       32'd1);
            chk({tag, " alu_op"},  32'(alu_op),     32'(eop));
            chk({tag, " alu_ac"},  32'(alu_ac),     32'(eac));
            chk({tag, " alu_bus"}, 32'(alu_bus),    32'(ebus));
            chk({tag, " rdy0 lo"}, 32'(req0_ready), 32'd0);
            chk({tag, " rdy1 lo"}, 32'(req1_ready), 32'd0);
            chk({tag, " rsp0 lo"}, 32'(rsp0_valid), 32'd0);
            chk({tag, " rsp1 lo"}, 32'(rsp1_valid), 32'd0);
        end
        @(negedge clk); #1;
        chk({tag, " busy done"},   32'(busy),   32'd0);
        chk({tag, " alu_op idle"}, 32'(alu_op), 32'(IDLE_OP));
        chk({tag, " alu_ac idle"}, 32'(alu_ac), 32'd0);
        chk({tag, " rsp0_valid"},  32'(rsp0_valid), 32'(!v.gnt));
        chk({tag, " rsp1_valid"},  32'(rsp1_valid), 32'(v.gnt));
        if (v.gnt) chk({tag, " rsp1_result"}, 32'(rsp1_result), 32'(v.res));
        else       chk({tag, " rsp0_result"}, 32'(rsp0_result), 32'(v.res));
    endtask

    vec_t vecs[8];

    initial begin
        // Requests held valid through reset must not be granted.
        reset = 1'b1;
        req0_valid = 1'b1; req0_op = OP_XOR; req0_ac = 12'h111; req0_bus = 12'h222;
        req1_valid = 1'b1; req1_op = OP_XOR; req1_ac = 12'h333; req1_bus = 12'h444;
        b_req0_valid = 1'b1; b_req0_op = OP_XOR; b_req0_ac = 12'h0; b_req0_bus = 12'h0;
        b_req1_valid = 1'b0; b_req1_op = 3'b000; b_req1_ac = 12'h0; b_req1_bus = 12'h0;

        vecs[0] = mk(1, OP_XOR, 12'h0CC, 12'h0C8, 0, OP_XOR, 12'h000, 12'h000, 0, 12'h004);
        vecs[1] = mk(0, OP_XOR, 12'h000, 12'h000, 1, OP_ADD, 12'h123, 12'h456, 1, 12'h579);
`ifdef ALU_ARB_FIXED_PRIO_EN
        vecs[2] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 0, 12'hF0F);
        vecs[3] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 0, 12'hF0F);
        vecs[4] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 0, 12'hF0F);
        vecs[5] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 0, 12'hF0F);
`else
        vecs[2] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 0, 12'hF0F);
        vecs[3] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 1, 12'hFFF);
        vecs[4] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 0, 12'hF0F);
        vecs[5] = mk(1, OP_XOR, 12'hFFF, 12'h0F0, 1, OP_XOR, 12'hAAA, 12'h555, 1, 12'hFFF);
`endif
        vecs[6] = mk(0, OP_XOR, 12'h000, 12'h000, 1, OP_XOR, 12'h0F0, 12'h00F, 1, 12'h0FF);
        vecs[7] = mk(1, OP_AND, 12'hF0F, 12'h0FF, 0, OP_XOR, 12'h000, 12'h000, 0, 12'h00F);

        #2 reset = 1'b0;
        #2;
        chk("rst ready0",      32'(req0_ready),  32'd0);
        chk("rst ready1",      32'(req1_ready),  32'd0);
        chk("rst busy",        32'(busy),        32'd0);
        chk("rst alu_op",      32'(alu_op),      32'(IDLE_OP));
        chk("rst alu_ac",      32'(alu_ac),      32'd0);
        chk("rst alu_bus",     32'(alu_bus),     32'd0);
        chk("rst rsp0_valid",  32'(rsp0_valid),  32'd0);
        chk("rst rsp1_valid",  32'(rsp1_valid),  32'd0);
        chk("rst rsp0_result", 32'(rsp0_result), 32'd0);
        chk("rst rsp1_result", 32'(rsp1_result), 32'd0);
        chk("rst b_ready0",    32'(b_req0_ready), 32'd0);
        chk("rst b_busy",      32'(b_busy),       32'd0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; b_req0_valid = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during EXEC abandons the operation without a response pulse.
        req0_valid = 1'b1; req0_op = OP_XOR; req0_ac = 12'h0AB; req0_bus = 12'h0BA;
        req1_valid = 1'b0;
        #1 chk("midrst ready0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk); #1;
        chk("midrst busy exec", 32'(busy),   32'd1);
        chk("midrst alu_ac",    32'(alu_ac), 32'h0AB);
        reset = 1'b0;
        #1;
        chk("midrst busy",        32'(busy),        32'd0);
        chk("midrst alu_op",      32'(alu_op),      32'(IDLE_OP));
        chk("midrst alu_ac0",     32'(alu_ac),      32'd0);
        chk("midrst alu_bus0",    32'(alu_bus),     32'd0);
        chk("midrst rsp0_valid",  32'(rsp0_valid),  32'd0);
        chk("midrst rsp0_result", 32'(rsp0_result), 32'd0);
        chk("midrst rsp1_result", 32'(rsp1_result), 32'd0);
        chk("midrst ready0 lo",   32'(req0_ready),  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("midrst no rsp0", 32'(rsp0_valid), 32'd0);
            chk("midrst no rsp1", 32'(rsp1_valid), 32'd0);
            chk("midrst busy lo", 32'(busy),       32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        run_vec(mk(1, OP_XOR, 12'h0AB, 12'h0BA, 0, OP_XOR, 12'h000, 12'h000, 0, 12'h011), "post-rst");

        // Idle drive with no requests.
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("idle alu_op",  32'(alu_op),  32'(IDLE_OP));
            chk("idle alu_ac",  32'(alu_ac),  32'd0);
            chk("idle alu_bus", 32'(alu_bus), 32'd0);
            chk("idle busy",    32'(busy),    32'd0);
        end

        // Latency-3 instance: busy for 4 cycles, response in the 5th cycle after acceptance.
        b_req0_valid = 1'b1; b_req0_op = OP_XOR; b_req0_ac = 12'h123; b_req0_bus = 12'h321;
        #1 chk("lat3 ready0", 32'(b_req0_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            b_req0_valid = 1'b0;
            chk($sformatf("lat3 busy c%0d", c),   32'(b_busy),       32'd1);
            chk($sformatf("lat3 alu_ac c%0d", c), 32'(b_alu_ac),     32'h123);
            chk($sformatf("lat3 rsp0 c%0d", c),   32'(b_rsp0_valid), 32'd0);
        end
        @(negedge clk); #1;
        chk("lat3 busy done",  32'(b_busy),        32'd0);
        chk("lat3 rsp0_valid", 32'(b_rsp0_valid),  32'd1);
        chk("lat3 rsp0_result",32'(b_rsp0_result), 32'h202);
        chk("lat3 rsp1_valid", 32'(b_rsp1_valid),  32'd0);
        @(negedge clk); #1;
        chk("lat3 pulse end",  32'(b_rsp0_valid),  32'd0);
        chk("lat3 result held",32'(b_rsp0_result), 32'h202);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
